// File: rtl/imem_boot_pkg.sv
// Shared state encoding and constants for the instruction-memory boot loader.
// IMEM_BOOT_CHECKSUM_EN adds the trailing checksum state.
package imem_boot_pkg;

  localparam int BYTES_PER_WORD     = 4;
  localparam int DEFAULT_ROM_BLOCKS = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
`ifdef IMEM_BOOT_CHECKSUM_EN
    ,
    ST_CHECK = 3'd5
`endif
  } state_t;

  // A load request is legal only for a non-empty image that fits the memory.
  function automatic logic count_valid(input logic [31:0] count, input logic [31:0] depth);
    return (count != 32'd0) && (count <= depth);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four stream bytes MSB-first into a 32-bit word; word_valid pulses
// in the cycle the fourth byte is accepted, with word already complete.
module imem_word_assembler
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt_reg;
  logic [23:0] partial_reg;

  // Only the first three bytes need storage; the fourth is merged combinationally.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      byte_cnt_reg <= '0;
      partial_reg  <= '0;
    end else if (byte_en) begin
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
      partial_reg  <= {partial_reg[15:0], byte_in};
    end
  end

  assign word       = {partial_reg, byte_in};
  assign word_valid = byte_en && (byte_cnt_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader for the instruction memory: streams an image in, holds the core
// in reset until loaded. Optional checksum byte: IMEM_BOOT_CHECKSUM_EN.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ROM_BLOCKS_NUM = DEFAULT_ROM_BLOCKS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_word_count,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_wr_en,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_cpu_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] count_reg, count_next;
  logic [ADDR_WIDTH-1:0] word_idx_reg, word_idx_next, idx_inc;
  logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_next;
  logic                  idle_like, start_accept, start_ok;
  logic                  asm_byte_en, word_valid;
  logic [31:0]           asm_word;

  assign idle_like    = (state_reg == ST_IDLE) || (state_reg == ST_DONE) || (state_reg == ST_ERR);
  assign start_accept = i_start && idle_like;
  assign start_ok     = count_valid(32'(i_word_count), 32'(ROM_BLOCKS_NUM));
  assign asm_byte_en  = i_byte_valid && (state_reg == ST_RECV);
  assign idx_inc      = word_idx_reg + ADDR_WIDTH'(1);

  imem_word_assembler u_asm (
    .clk        (i_clk),
    .srst       (i_rst),
    .clear      (start_accept),
    .byte_en    (asm_byte_en),
    .byte_in    (i_byte),
    .word       (asm_word),
    .word_valid (word_valid)
  );

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0] xor_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || start_accept) xor_reg <= '0;
    else if (asm_byte_en)      xor_reg <= xor_reg ^ i_byte;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      word_idx_reg <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      word_idx_reg <= word_idx_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    word_idx_next = word_idx_reg;
    wr_data_next  = wr_data_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) begin
          if (start_ok) begin
            state_next    = ST_RECV;
            count_next    = i_word_count;
            word_idx_next = '0;
          end else begin
            state_next = ST_ERR;
          end
        end
      end
      ST_RECV: begin
        if (word_valid) begin
          wr_data_next = DATA_WIDTH'(asm_word);
          state_next   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        word_idx_next = idx_inc;
        if (idx_inc == count_reg) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          state_next = ST_CHECK;
`else
          state_next = ST_DONE;
`endif
        end else begin
          state_next = ST_RECV;
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CHECK: begin
        if (i_byte_valid) state_next = (i_byte == xor_reg) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  assign o_byte_ready = (state_reg == ST_RECV) || (state_reg == ST_CHECK);
`else
  assign o_byte_ready = (state_reg == ST_RECV);
`endif
  assign o_wr_en    = (state_reg == ST_WRITE);
  assign o_wr_data  = wr_data_reg;
  assign o_busy     = (state_reg == ST_RECV) || (state_reg == ST_WRITE);
  assign o_done     = (state_reg == ST_DONE);
  assign o_err      = (state_reg == ST_ERR);
  assign o_cpu_rst  = (state_reg != ST_DONE);
  // Fetch path owns the memory address whenever no load is running.
  assign o_mem_addr = idle_like ? i_cpu_addr : word_idx_reg;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed self-checking bench for imem_boot_ctrl; covers the checksum
// state as well when IMEM_BOOT_CHECKSUM_EN is defined.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] cpu_addr = '0;
  logic [31:0] mem_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        cpu_rst, busy, done, err;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int wr_cnt = 0;
  logic [31:0] wr_addr_log [64];
  logic [31:0] wr_data_log [64];

  imem_boot_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_word_count (word_count),
    .i_byte       (byte_in),
    .i_byte_valid (byte_valid),
    .o_byte_ready (byte_ready),
    .i_cpu_addr   (cpu_addr),
    .o_mem_addr   (mem_addr),
    .o_wr_en      (wr_en),
    .o_wr_data    (wr_data),
    .o_cpu_rst    (cpu_rst),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en && wr_cnt < 64) begin
      wr_addr_log[wr_cnt] <= mem_addr;
      wr_data_log[wr_cnt] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] cnt);
    start = 1'b1;
    word_count = cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input logic [7:0] bytes_q[$], input bit gaps);
    for (int i = 0; i < bytes_q.size(); i++) begin
      int waited;
      waited = 0;
      if (gaps) begin
        byte_valid = 1'b0;
        tick();
      end
      byte_valid = 1'b1;
      byte_in = bytes_q[i];
      while (!byte_ready && waited < 20) begin
        tick();
        waited++;
      end
      tests_run++;
      if (byte_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_ready byte %0d: ready=%b required 1", i, byte_ready);
        byte_valid = 1'b0;
        return;
      end
      tick();
    end
    byte_valid = 1'b0;
  endtask

  // Leave the last WRITE; with the checksum build also supply the check byte.
  task automatic finish_load(input logic [7:0] csum);
    tick();
`ifdef IMEM_BOOT_CHECKSUM_EN
    byte_valid = 1'b1;
    byte_in = csum;
    tick();
    byte_valid = 1'b0;
`else
    byte_in = csum;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_addr = 32'h33;
    tick();
    tick();
    tests_run++;
    if ({byte_ready, wr_en, busy, done, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: ready/wr_en/busy/done/err=%b required 00000", {byte_ready, wr_en, busy, done, err});
    end
    tests_run++;
    if (cpu_rst !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_cpu_rst: got %b required 1", cpu_rst);
    end
    tests_run++;
    if (wr_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_wr_data: got %h required 00000000", wr_data);
    end
    tests_run++;
    if (mem_addr !== 32'h33) begin
      tests_failed++;
      $display("FAIL reset_mem_addr: got %h required 00000033", mem_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    int base, t0;
    base = wr_cnt;
    do_start(32'd2);
    t0 = cyc;
    tests_run++;
    if (busy !== 1'b1 || cpu_rst !== 1'b1 || byte_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_recv: busy/cpu_rst/ready=%b%b%b required 111", busy, cpu_rst, byte_ready);
    end
    stream('{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h00}, 1'b0);
    tests_run++;
    if (wr_en !== 1'b1 || (cyc - t0) != 9) begin
      tests_failed++;
      $display("FAIL basic_throughput: wr_en=%b after %0d cycles required 1 after 9", wr_en, cyc - t0);
    end
    finish_load(8'h88);
    tests_run++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done: done/cpu_rst/busy/err=%b%b%b%b required 1000", done, cpu_rst, busy, err);
    end
    tests_run++;
    if (wr_cnt - base != 2) begin
      tests_failed++;
      $display("FAIL basic_write_count: got %0d required 2", wr_cnt - base);
    end else begin
      tests_run++;
      if (wr_addr_log[base] !== 32'd0 || wr_data_log[base] !== 32'h20080005) begin
        tests_failed++;
        $display("FAIL basic_word0: @%h=%h required @00000000=20080005", wr_addr_log[base], wr_data_log[base]);
      end
      tests_run++;
      if (wr_addr_log[base+1] !== 32'd1 || wr_data_log[base+1] !== 32'hAC090000) begin
        tests_failed++;
        $display("FAIL basic_word1: @%h=%h required @00000001=ac090000", wr_addr_log[base+1], wr_data_log[base+1]);
      end
    end
  endtask

  task automatic test_bad_count();
    int base;
    base = wr_cnt;
    do_start(32'd0);
    tests_run++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bad_count_zero: err/cpu_rst/busy=%b%b%b required 110", err, cpu_rst, busy);
    end
    do_start(32'd257);
    tick();
    tests_run++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || byte_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bad_count_257: err/cpu_rst/ready=%b%b%b required 110", err, cpu_rst, byte_ready);
    end
    tests_run++;
    if (wr_cnt != base) begin
      tests_failed++;
      $display("FAIL bad_count_writes: got %0d writes required 0", wr_cnt - base);
    end
    do_start(32'd256);
    tests_run++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL count_256_accepted: busy/err=%b%b required 10", busy, err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_valid_gaps();
    int base, t0;
    base = wr_cnt;
    do_start(32'd1);
    t0 = cyc;
    stream('{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b1);
    tests_run++;
    if (wr_en !== 1'b1 || (cyc - t0) != 8) begin
      tests_failed++;
      $display("FAIL gaps_timing: wr_en=%b after %0d cycles required 1 after 8", wr_en, cyc - t0);
    end
    finish_load(8'h22);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL gaps_done: got %b required 1", done);
    end
    tests_run++;
    if (wr_cnt - base != 1 || wr_addr_log[base] !== 32'd0 || wr_data_log[base] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL gaps_word: %0d writes, @%h=%h required 1 write @00000000=deadbeef",
               wr_cnt - base, wr_addr_log[base], wr_data_log[base]);
    end
  endtask

  task automatic test_reset_mid_load();
    int base;
    cpu_addr = 32'h7;
    do_start(32'd2);
    stream('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 1'b0);
    start = 1'b1;
    word_count = 32'd0;
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_ignored_in_recv: busy/err=%b%b required 10", busy, err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || cpu_rst !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midload_reset: busy/cpu_rst/ready/done=%b%b%b%b required 0100", busy, cpu_rst, byte_ready, done);
    end
    tests_run++;
    if (mem_addr !== 32'h7 || wr_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL midload_reset_regs: mem_addr=%h wr_data=%h required 00000007/00000000", mem_addr, wr_data);
    end
    base = wr_cnt;
    do_start(32'd1);
    stream('{8'h0A, 8'h0B, 8'h0C, 8'h0D}, 1'b0);
    finish_load(8'h00);
    tests_run++;
    if (wr_cnt - base != 1 || wr_addr_log[base] !== 32'd0 || wr_data_log[base] !== 32'h0A0B0C0D || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL reload_after_reset: %0d writes, @%h=%h done=%b required 1 write @00000000=0a0b0c0d done=1",
               wr_cnt - base, wr_addr_log[base], wr_data_log[base], done);
    end
  endtask

  task automatic test_done_addr();
    cpu_addr = 32'd5;
    #1;
    tests_run++;
    if (mem_addr !== 32'd5 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_fetch_addr: mem_addr=%h done=%b required 00000005/1", mem_addr, done);
    end
    do_start(32'd1);
    tests_run++;
    if (cpu_rst !== 1'b1 || done !== 1'b0 || mem_addr !== 32'd0) begin
      tests_failed++;
      $display("FAIL reload_cpu_rst: cpu_rst/done=%b%b mem_addr=%h required 10/00000000", cpu_rst, done, mem_addr);
    end
    stream('{8'h12, 8'h34, 8'h56, 8'h78}, 1'b0);
    tests_run++;
    if (wr_en !== 1'b1 || mem_addr !== 32'd0 || wr_data !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL reload_write: wr_en=%b @%h=%h required 1 @00000000=12345678", wr_en, mem_addr, wr_data);
    end
    finish_load(8'h08);
    tests_run++;
    if (done !== 1'b1 || mem_addr !== 32'd5 || byte_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reload_done: done=%b mem_addr=%h ready=%b required 1/00000005/0", done, mem_addr, byte_ready);
    end
  endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
  task automatic test_checksum();
    do_start(32'd1);
    stream('{8'h01, 8'h02, 8'h03, 8'h04}, 1'b0);
    tick();
    tests_run++;
    if (byte_ready !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL check_state: ready/done=%b%b required 10", byte_ready, done);
    end
    byte_valid = 1'b1;
    byte_in = 8'h04;
    tick();
    byte_valid = 1'b0;
    tests_run++;
    if (done !== 1'b1 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL checksum_match: done/err=%b%b required 10", done, err);
    end
    do_start(32'd1);
    stream('{8'h01, 8'h02, 8'h03, 8'h04}, 1'b0);
    tick();
    byte_valid = 1'b1;
    byte_in = 8'h05;
    tick();
    byte_valid = 1'b0;
    tests_run++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1) begin
      tests_failed++;
      $display("FAIL checksum_mismatch: err/done/cpu_rst=%b%b%b required 101", err, done, cpu_rst);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_bad_count();
    test_valid_gaps();
    test_reset_mid_load();
    test_done_addr();
`ifdef IMEM_BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
